// File: rtl/tcb_arb_pkg.sv
// tcb_arb_pkg: arbitration mode and lock-state types shared by the TCB arbiter
package tcb_arb_pkg;
  typedef enum logic {TCB_ARB_FIX, TCB_ARB_RR} tcb_arb_mode_t;
  typedef enum logic {TCB_ARB_IDLE, TCB_ARB_LCK} tcb_arb_lck_t;
endpackage

// File: rtl/tcb_arb_pri.sv
// tcb_arb_pri: rotating priority encoder, first set request at or above ptr wins
module tcb_arb_pri #(
  parameter int PN = 2,
  localparam int IW = $clog2(PN)
) (
  input  logic [PN-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [PN-1:0] gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // scan from the farthest offset down so the nearest request overwrites last
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = PN-1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % PN);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/tcb_arb.sv
// tcb_arb: merges PN TCB managers onto one manager port with grant locking
// and one-cycle-delayed response routing back to the completing manager.
module tcb_arb import tcb_arb_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int PN = 2,
  parameter tcb_arb_mode_t MODE = TCB_ARB_RR,
  localparam int IW = $clog2(PN),
  localparam int BW = DW/8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PN-1:0]    s_vld,
  input  logic [PN-1:0]    s_wen,
  input  logic [PN*BW-1:0] s_ben,
  input  logic [PN*AW-1:0] s_adr,
  input  logic [PN*DW-1:0] s_wdt,
  output logic [PN*DW-1:0] s_rdt,
  output logic [PN-1:0]    s_err,
  output logic [PN-1:0]    s_rdy,
  output logic             m_vld,
  output logic             m_wen,
  output logic [BW-1:0]    m_ben,
  output logic [AW-1:0]    m_adr,
  output logic [DW-1:0]    m_wdt,
  input  logic [DW-1:0]    m_rdt,
  input  logic             m_err,
  input  logic             m_rdy
);
  tcb_arb_lck_t  lck_q, lck_d;
  logic [PN-1:0] lck_gnt_q, lck_gnt_d;
  logic [IW-1:0] ptr_q, ptr_d, rsp_sel_q, rsp_sel_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [PN-1:0] pri_gnt, gnt;
  logic [IW-1:0] pri_idx, gnt_idx;
  logic          hs;
  logic [BW-1:0] ben_a [PN];
  logic [AW-1:0] adr_a [PN];
  logic [DW-1:0] wdt_a [PN];

  tcb_arb_pri #(.PN(PN)) u_pri (
    .req (s_vld),
    .ptr (MODE == TCB_ARB_FIX ? '0 : ptr_q),
    .gnt (pri_gnt),
    .idx (pri_idx)
  );

  for (genvar i = 0; i < PN; i++) begin : g_port
    assign ben_a[i] = s_ben[i*BW +: BW];
    assign adr_a[i] = s_adr[i*AW +: AW];
    assign wdt_a[i] = s_wdt[i*DW +: DW];
    assign s_err[i] = m_err & rsp_vld_q & (rsp_sel_q == IW'(i));
  end

  assign s_rdt = {PN{m_rdt}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lck_q     <= TCB_ARB_IDLE;
      lck_gnt_q <= '0;
      ptr_q     <= '0;
      rsp_sel_q <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      lck_q     <= lck_d;
      lck_gnt_q <= lck_gnt_d;
      ptr_q     <= ptr_d;
      rsp_sel_q <= rsp_sel_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  // a stall locks the grant; completion or a dropped request releases it
  always_comb begin
    lck_d = lck_q;
    if (lck_q == TCB_ARB_IDLE)
      lck_d = (m_vld & ~m_rdy) ? TCB_ARB_LCK : TCB_ARB_IDLE;
    else
      lck_d = (~m_vld | m_rdy) ? TCB_ARB_IDLE : TCB_ARB_LCK;
    lck_gnt_d = (lck_q == TCB_ARB_IDLE && m_vld && !m_rdy) ? gnt : lck_gnt_q;
    ptr_d     = hs ? ((gnt_idx == IW'(PN-1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
    rsp_sel_d = hs ? gnt_idx : rsp_sel_q;
    rsp_vld_d = hs;
  end

  always_comb begin
    gnt = (lck_q == TCB_ARB_LCK) ? lck_gnt_q : pri_gnt;
    gnt_idx = '0;
    for (int k = 0; k < PN; k++)
      if (gnt[k]) gnt_idx = IW'(k);
    m_vld = |(s_vld & gnt);
    hs    = m_vld & m_rdy;
    s_rdy = gnt & {PN{m_rdy}};
    m_wen = |gnt ? s_wen[gnt_idx] : 1'bx;
    m_ben = |gnt ? ben_a[gnt_idx] : 'x;
    m_adr = |gnt ? adr_a[gnt_idx] : 'x;
    m_wdt = |gnt ? wdt_a[gnt_idx] : 'x;
  end
endmodule

// File: tb/tb_tcb_arb.sv
// tb_tcb_arb: directed checks of a round-robin and a fixed-priority arbiter
// driven by the same three-manager stimulus.
module tb_tcb_arb;
  import tcb_arb_pkg::*;
  localparam int PN = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [PN-1:0] s_vld = '0, s_wen = '0;
  logic [PN*4-1:0] s_ben = '0;
  logic [PN*32-1:0] s_adr = '0, s_wdt = '0;
  logic [31:0] m_rdt = '0;
  logic m_err = 1'b0, m_rdy = 1'b1;
  logic [PN*32-1:0] rr_s_rdt, fx_s_rdt;
  logic [PN-1:0] rr_s_err, rr_s_rdy, fx_s_err, fx_s_rdy;
  logic rr_m_vld, rr_m_wen, fx_m_vld, fx_m_wen;
  logic [3:0] rr_m_ben, fx_m_ben;
  logic [31:0] rr_m_adr, rr_m_wdt, fx_m_adr, fx_m_wdt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tcb_arb #(.AW(32), .DW(32), .PN(PN), .MODE(TCB_ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben),
    .s_adr(s_adr), .s_wdt(s_wdt), .s_rdt(rr_s_rdt), .s_err(rr_s_err),
    .s_rdy(rr_s_rdy), .m_vld(rr_m_vld), .m_wen(rr_m_wen), .m_ben(rr_m_ben),
    .m_adr(rr_m_adr), .m_wdt(rr_m_wdt), .m_rdt(m_rdt), .m_err(m_err), .m_rdy(m_rdy)
  );

  tcb_arb #(.AW(32), .DW(32), .PN(PN), .MODE(TCB_ARB_FIX)) dut_fx (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben),
    .s_adr(s_adr), .s_wdt(s_wdt), .s_rdt(fx_s_rdt), .s_err(fx_s_err),
    .s_rdy(fx_s_rdy), .m_vld(fx_m_vld), .m_wen(fx_m_wen), .m_ben(fx_m_ben),
    .m_adr(fx_m_adr), .m_wdt(fx_m_wdt), .m_rdt(m_rdt), .m_err(m_err), .m_rdy(m_rdy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_err", 128'(rr_s_err), 128'(3'b000));
    chk("rst_rdy", 128'(rr_s_rdy), 128'(3'b000));
    chk("rst_mvld", 128'(rr_m_vld), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    tick;
    // single manager on port 1
    s_vld = 3'b010; s_wen = 3'b010; s_ben[4 +: 4] = 4'hf;
    s_adr[32 +: 32] = 32'h100; s_wdt[32 +: 32] = 32'hdeadbeef; m_rdy = 1'b1;
    #1;
    chk("single_mvld", 128'(rr_m_vld), 128'(1'b1));
    chk("single_adr", 128'(rr_m_adr), 128'(32'h100));
    chk("single_wdt", 128'(rr_m_wdt), 128'(32'hdeadbeef));
    chk("single_wen", 128'(rr_m_wen), 128'(1'b1));
    chk("single_ben", 128'(rr_m_ben), 128'(4'hf));
    chk("single_rdy", 128'(rr_s_rdy), 128'(3'b010));
    tick;
    s_vld = 3'b000; m_err = 1'b1;
    #1;
    chk("single_rsp_sel", 128'(rr_s_err), 128'(3'b010));
    chk("single_idle_mvld", 128'(rr_m_vld), 128'(1'b0));
    // all managers request every cycle
    rst_pulse;
    s_vld = 3'b111; s_wen = 3'b000;
    s_adr = {32'h20, 32'h10, 32'h00};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_rdy_%0d", c), 128'(rr_s_rdy), 128'(3'b001 << (c % 3)));
      chk($sformatf("rr_adr_%0d", c), 128'(rr_m_adr), 128'(32'(16 * (c % 3))));
      chk($sformatf("fx_rdy_%0d", c), 128'(fx_s_rdy), 128'(3'b001));
      chk($sformatf("rr_err_%0d", c), 128'(rr_s_err),
          128'(c == 0 ? 3'b000 : 3'b001 << ((c - 1) % 3)));
      chk($sformatf("fx_err_%0d", c), 128'(fx_s_err), 128'(c == 0 ? 3'b000 : 3'b001));
      tick;
    end
    // stalled port 1 keeps the grant against a later port-0 request
    rst_pulse;
    m_err = 1'b0; m_rdy = 1'b0; s_vld = 3'b010;
    s_adr[0 +: 32] = 32'h300; s_adr[32 +: 32] = 32'h200;
    #1;
    chk("lck_mvld", 128'(rr_m_vld), 128'(1'b1));
    chk("lck_adr0", 128'(rr_m_adr), 128'(32'h200));
    chk("lck_rdy0", 128'(rr_s_rdy), 128'(3'b000));
    tick;
    s_vld = 3'b011;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("lck_rr_adr_%0d", c), 128'(rr_m_adr), 128'(32'h200));
      chk($sformatf("lck_fx_adr_%0d", c), 128'(fx_m_adr), 128'(32'h200));
      chk($sformatf("lck_fx_rdy_%0d", c), 128'(fx_s_rdy), 128'(3'b000));
      tick;
    end
    m_rdy = 1'b1;
    #1;
    chk("lck_rel_rr", 128'(rr_s_rdy), 128'(3'b010));
    chk("lck_rel_fx", 128'(fx_s_rdy), 128'(3'b010));
    tick;
    chk("lck_next_rr", 128'(rr_s_rdy), 128'(3'b001));
    chk("lck_next_adr", 128'(rr_m_adr), 128'(32'h300));
    chk("lck_next_fx", 128'(fx_s_rdy), 128'(3'b001));
    // response routed to port 2, then cleared by async reset
    rst_pulse;
    s_vld = 3'b100;
    #1;
    chk("err_rdy", 128'(rr_s_rdy), 128'(3'b100));
    tick;
    s_vld = 3'b000; m_err = 1'b1; m_rdt = 32'h12345678;
    #1;
    chk("err_rr", 128'(rr_s_err), 128'(3'b100));
    chk("err_fx", 128'(fx_s_err), 128'(3'b100));
    chk("err_rdt", 128'(rr_s_rdt), 128'({3{32'h12345678}}));
    rst = 1'b1;
    #1;
    chk("err_async_rst", 128'(rr_s_err), 128'(3'b000));
    rst = 1'b0;
    m_err = 1'b0;
    tick;
    // async reset while locked with ptr = 2
    s_vld = 3'b010; m_rdy = 1'b1;
    tick;
    m_rdy = 1'b0;
    tick;
    chk("pre_rst_lck", 128'(dut_rr.lck_q), 128'(TCB_ARB_LCK));
    chk("pre_rst_ptr", 128'(dut_rr.ptr_q), 128'(2'd2));
    rst = 1'b1;
    s_vld = 3'b011;
    #1;
    chk("rst_lck", 128'(dut_rr.lck_q), 128'(TCB_ARB_IDLE));
    chk("rst_ptr", 128'(dut_rr.ptr_q), 128'(2'd0));
    chk("rst_err_mid", 128'(rr_s_err), 128'(3'b000));
    chk("rst_adr_mid", 128'(rr_m_adr), 128'(32'h300));
    rst = 1'b0; m_rdy = 1'b1;
    #1;
    chk("post_rst_rdy", 128'(rr_s_rdy), 128'(3'b001));
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
